calculator_core: RTL and testbench

Arithmetic core for the music calculator. It consumes the keypad decoder's one-cycle event strobes (`num`/`numPressed`, `opt`/`optPressed`, `submit`) and builds two decimal operands of up to four digits. On submit it runs a multi-cycle add/subtract/multiply/divide followed by a binary-to-BCD conversion. It drives four BCD digits straight into the four-digit LED driver's `num1..num4` inputs.

---
 rtl/calculator_core.sv | 187 ++++++++++++++++++
 tb/tb_calculator_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/calculator_core.sv
// Four-digit decimal calculator core: keypad-driven operand entry, multi-cycle
// add/sub/mul/div, then double-dabble conversion onto four BCD display digits.
module calculator_core #(
    parameter int unsigned MAXDIG = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       numPressed,
    input  logic [2:0] opt,
    input  logic       optPressed,
    input  logic       submit,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {ENTRY_A, ENTRY_B, CALC, CONV, SHOW, ERROR} state_t;

    state_t      state_q, state_d;
    logic [13:0] a_q, a_d, b_q, b_d, result_q, result_d, dq_q, dq_d, rem_q, rem_d;
    logic [27:0] prod_q, prod_d;
    logic [15:0] disp_q, disp_d, bcd_q, bcd_d;
    logic [2:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  cyc_q, cyc_d;
    logic        done_q, done_d;

    // Only the highest-priority strobe of a cycle is decoded.
    logic do_opt, do_num, is_clear, is_op, dig_ok, a_room, b_room;
    assign do_opt   = optPressed && !submit;
    assign do_num   = numPressed && !submit && !optPressed;
    assign is_clear = do_opt && (opt == 3'd4);
    assign is_op    = do_opt && !opt[2];
    assign dig_ok   = do_num && (num <= 4'd9);
    assign a_room   = 32'(cnt_a_q) < MAXDIG;
    assign b_room   = 32'(cnt_b_q) < MAXDIG;

    logic [14:0] sum, rem_sh, rem_diff;
    logic [27:0] prod_nxt;
    logic [13:0] rem_nxt, dq_nxt, calc_res;
    logic [15:0] bcd_adj, bcd_nxt;
    logic        qbit, calc_err, calc_last, conv_last;

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        prod_nxt = prod_q + (b_q[cyc_q] ? ({14'b0, a_q} << cyc_q) : '0);
        rem_sh   = {rem_q, dq_q[13]};
        rem_diff = rem_sh - {1'b0, b_q};
        qbit     = rem_sh >= {1'b0, b_q};
        rem_nxt  = qbit ? rem_diff[13:0] : rem_sh[13:0];
        dq_nxt   = {dq_q[12:0], qbit};
        calc_res = '0;
        calc_err = 1'b0;
        case (op_q)
            2'd0: begin calc_res = sum[13:0];      calc_err = sum > 15'd9999;       end
            2'd1: begin calc_res = a_q - b_q;      calc_err = a_q < b_q;            end
            2'd2: begin calc_res = prod_nxt[13:0]; calc_err = prod_nxt > 28'd9999;  end
            2'd3: begin calc_res = dq_nxt;         calc_err = b_q == '0;            end
        endcase
        calc_last = !op_q[1] || (cyc_q == 4'd13) || (op_q == 2'd3 && b_q == '0);
        conv_last = cyc_q == 4'd13;
        for (int unsigned i = 0; i < 4; i++)
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        bcd_nxt = {bcd_adj[14:0], dq_q[13]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ENTRY_A;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            prod_q   <= '0;
            disp_q   <= '0;
            bcd_q    <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            op_q     <= '0;
            cyc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            prod_q   <= prod_d;
            disp_q   <= disp_d;
            bcd_q    <= bcd_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            op_q     <= op_d;
            cyc_q    <= cyc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_clear) state_d = ENTRY_A;
        else begin
            case (state_q)
                ENTRY_A: if (is_op) state_d = ENTRY_B;
                ENTRY_B: if (submit) state_d = CALC;
                CALC:    if (calc_last) state_d = calc_err ? ERROR : CONV;
                CONV:    if (conv_last) state_d = SHOW;
                SHOW:    if (is_op) state_d = ENTRY_B;
                         else if (dig_ok) state_d = ENTRY_A;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        a_d = a_q; b_d = b_q; result_d = result_q; dq_d = dq_q; rem_d = rem_q;
        prod_d = prod_q; disp_d = disp_q; bcd_d = bcd_q; cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q; op_d = op_q; cyc_d = cyc_q; done_d = 1'b0;
        if (is_clear) begin
            a_d = '0; b_d = '0; cnt_a_d = '0; cnt_b_d = '0; disp_d = '0; cyc_d = '0;
        end else begin
            case (state_q)
                ENTRY_A: begin
                    if (is_op) begin
                        op_d = opt[1:0]; b_d = '0; cnt_b_d = '0;
                    end else if (dig_ok && a_room) begin
                        a_d     = a_q * 14'd10 + {10'b0, num};
                        disp_d  = {disp_q[11:0], num};
                        cnt_a_d = cnt_a_q + 3'd1;
                    end
                end
                ENTRY_B: begin
                    if (submit) begin
                        cyc_d = '0; prod_d = '0; rem_d = '0; dq_d = a_q;
                    end else if (is_op) begin
                        if (cnt_b_q == '0) op_d = opt[1:0];
                    end else if (dig_ok && b_room) begin
                        b_d     = b_q * 14'd10 + {10'b0, num};
                        disp_d  = (cnt_b_q == '0) ? {12'b0, num} : {disp_q[11:0], num};
                        cnt_b_d = cnt_b_q + 3'd1;
                    end
                end
                CALC: begin
                    cyc_d  = cyc_q + 4'd1;
                    prod_d = prod_nxt;
                    rem_d  = rem_nxt;
                    dq_d   = dq_nxt;
                    if (calc_last) begin
                        if (calc_err) disp_d = 16'hEEEE;
                        else begin
                            result_d = calc_res; dq_d = calc_res; bcd_d = '0; cyc_d = '0;
                        end
                    end
                end
                CONV: begin
                    bcd_d = bcd_nxt;
                    dq_d  = {dq_q[12:0], 1'b0};
                    cyc_d = cyc_q + 4'd1;
                    if (conv_last) begin
                        disp_d = bcd_nxt; a_d = result_q; cnt_a_d = 3'd4; done_d = 1'b1;
                    end
                end
                SHOW: begin
                    if (is_op) begin
                        op_d = opt[1:0]; b_d = '0; cnt_b_d = '0;
                    end else if (dig_ok) begin
                        a_d = {10'b0, num}; cnt_a_d = 3'd1; disp_d = {12'b0, num};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == CALC) || (state_q == CONV);
        err  = state_q == ERROR;
        done = done_q;
        {num1, num2, num3, num4} = disp_q;
    end
endmodule

// File: tb/tb_calculator_core.sv
// Directed bench for calculator_core: keypad sequences with hand-computed
// displays, result/error latencies, clear/abort, priority and async reset.
module tb_calculator_core;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] num = '0;
    logic       numPressed = 1'b0;
    logic [2:0] opt = '0;
    logic       optPressed = 1'b0;
    logic       submit = 1'b0;
    logic [3:0] num1, num2, num3, num4;
    logic       busy, done, err;
    logic [15:0] disp;

    int n_checks = 0;
    int n_errors = 0;

    calculator_core dut (
        .clk(clk), .reset(reset), .num(num), .numPressed(numPressed),
        .opt(opt), .optPressed(optPressed), .submit(submit),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    assign disp = {num1, num2, num3, num4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All key tasks start and end 1 time unit after a rising edge.
    task automatic key(input logic [3:0] d);
        num = d; numPressed = 1'b1;
        @(posedge clk); #1;
        numPressed = 1'b0;
    endtask

    task automatic op(input logic [2:0] o);
        opt = o; optPressed = 1'b1;
        @(posedge clk); #1;
        optPressed = 1'b0;
    endtask

    // Pulses submit (optionally alongside a digit) and waits for done or err.
    task automatic run(input bit with_num, input logic [3:0] d,
                       output int lat, output bit saw_done, output bit saw_err, output bit busy_ok);
        submit = 1'b1; numPressed = with_num; num = d;
        @(posedge clk); #1;
        submit = 1'b0; numPressed = 1'b0;
        busy_ok = busy; lat = -1; saw_done = 1'b0; saw_err = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done || err) begin
                lat = k; saw_done = done; saw_err = err;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit sd, se, bo;
        bit any_done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_disp", disp, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 12 + 34 = 46
        key(1); key(2);
        check("add_a_disp", disp, 16'h0012);
        op(0);
        check("add_op_keeps_a", disp, 16'h0012);
        key(3);
        check("add_b_first", disp, 16'h0003);
        key(4);
        check("add_b_disp", disp, 16'h0034);
        run(0, 0, lat, sd, se, bo);
        check("add_lat", lat, 15);
        check("add_done", sd, 1);
        check("add_busy", bo, 1);
        check("add_res", disp, 16'h0046);
        @(posedge clk); #1;
        check("add_done_1cyc", done, 0);
        check("add_busy_low", busy, 0);
        op(4);
        check("clr_disp", disp, 16'h0000);

        // ENTRY_A submit does nothing
        key(6);
        submit = 1'b1; @(posedge clk); #1; submit = 1'b0;
        check("a_submit_nop", {busy, disp}, {1'b0, 16'h0006});
        op(4);

        // 9999 * 2 overflows
        key(9); key(9); key(9); key(9);
        op(2); key(2);
        run(0, 0, lat, sd, se, bo);
        check("mul_ovf_lat", lat, 14);
        check("mul_ovf_err", se, 1);
        check("mul_ovf_nodone", sd, 0);
        check("mul_ovf_disp", disp, 16'hEEEE);
        check("mul_ovf_busy", busy, 0);
        op(4);
        check("ovf_clr", {err, disp}, {1'b0, 16'h0000});

        // 7 / 2 = 3
        key(7); op(3); key(2);
        run(0, 0, lat, sd, se, bo);
        check("div_lat", lat, 28);
        check("div_res", disp, 16'h0003);
        op(4);

        // 7 / 0
        key(7); op(3); key(0);
        run(0, 0, lat, sd, se, bo);
        check("div0_lat", lat, 1);
        check("div0_err", {se, sd}, 2'b10);
        op(4);

        // 3 - 5
        key(3); op(1); key(5);
        run(0, 0, lat, sd, se, bo);
        check("sub_neg_lat", lat, 1);
        check("sub_neg_err", {se, disp}, {1'b1, 16'hEEEE});
        op(4);

        // Fifth digit and out-of-range digit ignored
        key(1); key(2); key(3); key(4); key(5);
        check("fifth_digit", disp, 16'h1234);
        key(11);
        check("digit_11", disp, 16'h1234);
        op(4);

        // 8 add->sub 3 = 5, then * 2 = 10
        key(8); op(0); op(1); key(3);
        run(0, 0, lat, sd, se, bo);
        check("chain_sub_lat", lat, 15);
        check("chain_sub_res", disp, 16'h0005);
        op(2);
        check("chain_op_keeps", disp, 16'h0005);
        key(2);
        check("chain_b", disp, 16'h0002);
        run(0, 0, lat, sd, se, bo);
        check("chain_mul_lat", lat, 28);
        check("chain_mul_res", disp, 16'h0010);
        op(4);

        // Clear aborts a multiply in CALC
        key(5); op(2); key(6);
        submit = 1'b1; @(posedge clk); #1; submit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_pre", busy, 1);
        op(4);
        check("abort_state", {busy, err, disp}, {2'b00, 16'h0000});
        any_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) any_done = 1'b1;
        end
        check("abort_no_done", any_done, 0);
        key(4);
        check("abort_entry_a", disp, 16'h0004);
        op(4);

        // submit beats a digit in the same cycle: 2 + 3, not 2 + 37
        key(2); op(0); key(3);
        run(1, 7, lat, sd, se, bo);
        check("prio_lat", lat, 15);
        check("prio_res", disp, 16'h0005);
        op(4);

        // Async reset mid-operation
        key(9); op(2); key(9);
        submit = 1'b1; @(posedge clk); #1; submit = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst", {busy, done, err, disp}, {3'b000, 16'h0000});
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {busy, disp}, {1'b0, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
